// File: rtl/node_feeder.sv
// node_feeder: buffers one input vector and its coefficients, sweeps them into an ANN node, returns the result.
// Define NODE_FEEDER_DBUF_EN for ping-pong data banks so the next vector can load while one is being swept.
module node_feeder #(
  parameter int N_IN     = 64,
  parameter int WORD_W   = 16,
  parameter int CNT_W    = 7,
  parameter int OUT_W    = 3,
  parameter int NODE_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WORD_W-1:0]        in_data,
  input  logic                     coef_we,
  input  logic [5:0]               coef_addr,
  input  logic [WORD_W-1:0]        coef_wdata,
  output logic [N_IN*WORD_W-1:0]   coef_flat,
  output logic [N_IN*WORD_W-1:0]   data_flat,
  output logic [CNT_W-1:0]         cnt_val,
  output logic                     node_clr,
  output logic                     node_en,
  input  logic [OUT_W-1:0]         node_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [OUT_W-1:0]         res_data,
  output logic                     busy
);
  localparam int DL_W = (NODE_LAT > 1) ? $clog2(NODE_LAT) : 1;

  typedef enum logic [1:0] {LOAD, SWEEP, DRAIN, HOLD} state_t;

  state_t          state;
  logic [5:0]      wr_ptr;
  logic [DL_W-1:0] drain_cnt;
  logic            accept;
  logic            last_word;

  // Both in_* and res_* follow valid/ready: a transfer happens on a clock edge where
  // valid and ready are both high; the producer holds valid and data stable until then.
  assign accept    = in_valid && in_ready;
  assign last_word = accept && (wr_ptr == 6'(N_IN - 1));
  assign busy      = (state != LOAD);

`ifdef NODE_FEEDER_DBUF_EN
  logic [N_IN*WORD_W-1:0] bank [2];
  logic [1:0]             full;
  logic                   wr_bank;
  logic                   sweep_bank;

  // wr_bank always names the bank not under sweep unless both banks are full.
  assign in_ready  = !full[wr_bank];
  assign data_flat = bank[sweep_bank];
`else
  assign in_ready  = (state == LOAD);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      wr_ptr    <= '0;
      drain_cnt <= '0;
      cnt_val   <= '0;
      node_clr  <= 1'b0;
      node_en   <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      coef_flat <= '0;
`ifdef NODE_FEEDER_DBUF_EN
      bank[0]    <= '0;
      bank[1]    <= '0;
      full       <= 2'b00;
      wr_bank    <= 1'b0;
      sweep_bank <= 1'b0;
`else
      data_flat <= '0;
`endif
    end else begin
      node_clr <= 1'b0;
      if (coef_we && state == LOAD)
        coef_flat[coef_addr*WORD_W +: WORD_W] <= coef_wdata;
      if (accept) begin
`ifdef NODE_FEEDER_DBUF_EN
        bank[wr_bank][wr_ptr*WORD_W +: WORD_W] <= in_data;
        if (last_word) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
        end
`else
        data_flat[wr_ptr*WORD_W +: WORD_W] <= in_data;
`endif
        wr_ptr <= wr_ptr + 6'd1;
      end
      case (state)
        LOAD: begin
          if (last_word) begin
            state    <= SWEEP;
            node_clr <= 1'b1;
            node_en  <= 1'b1;
            cnt_val  <= '0;
`ifdef NODE_FEEDER_DBUF_EN
            sweep_bank <= wr_bank;
`endif
          end
        end
        SWEEP: begin
          if (cnt_val == CNT_W'(N_IN - 1)) begin
            state     <= DRAIN;
            node_en   <= 1'b0;
            drain_cnt <= '0;
          end else begin
            cnt_val <= cnt_val + 1'b1;
          end
        end
        DRAIN: begin
          // Capture on the NODE_LAT-th cycle after the last index was presented.
          if (drain_cnt == DL_W'(NODE_LAT - 1)) begin
            res_data  <= node_out;
            res_valid <= 1'b1;
            cnt_val   <= '0;
            state     <= HOLD;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
`ifdef NODE_FEEDER_DBUF_EN
            full[sweep_bank] <= 1'b0;
            if (full[~sweep_bank] || last_word) begin
              state      <= SWEEP;
              node_clr   <= 1'b1;
              node_en    <= 1'b1;
              sweep_bank <= ~sweep_bank;
            end else
`endif
            state <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_node_feeder.sv
// Directed bench for node_feeder (default single-bank build): streaming, hold, ignore rules, mid-run reset, gaps.
module tb_node_feeder;
  localparam int N_IN = 64;
  localparam int WW   = 16;
  localparam int LAT  = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [WW-1:0]      in_data;
  logic               coef_we;
  logic [5:0]         coef_addr;
  logic [WW-1:0]      coef_wdata;
  logic [N_IN*WW-1:0] coef_flat;
  logic [N_IN*WW-1:0] data_flat;
  logic [6:0]         cnt_val;
  logic               node_clr;
  logic               node_en;
  logic [2:0]         node_out;
  logic               res_valid;
  logic               res_ready;
  logic [2:0]         res_data;
  logic               busy;

  int checks = 0;
  int errors = 0;

  node_feeder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .coef_flat(coef_flat), .data_flat(data_flat), .cnt_val(cnt_val),
    .node_clr(node_clr), .node_en(node_en), .node_out(node_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Streams base+i for i=0..63 on consecutive cycles; returns at cycle T+1.
  task automatic drive_vector(input logic [WW-1:0] base, input bit with_coef);
    for (int i = 0; i < N_IN; i++) begin
      in_valid = 1'b1;
      in_data  = base + WW'(i);
      if (with_coef) begin
        coef_we    = 1'b1;
        coef_addr  = 6'(i);
        coef_wdata = 16'd1;
      end
      step();
    end
    in_valid = 1'b0;
    coef_we  = 1'b0;
  endtask

  task automatic wait_res(input string name);
    int n = 0;
    while (!res_valid && n < 300) begin
      step();
      n++;
    end
    checks++;
    if (!res_valid) begin
      errors++;
      $display("FAIL %s: res_valid never rose within 300 cycles", name);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if ({busy, in_ready, node_clr, node_en, res_valid} !== 5'b01000) begin
      errors++;
      $display("FAIL reset_flags: got busy/in_ready/clr/en/res_valid=%b expected 01000",
               {busy, in_ready, node_clr, node_en, res_valid});
    end
    checks++;
    if (cnt_val !== 7'd0 || res_data !== 3'd0) begin
      errors++;
      $display("FAIL reset_cnt: cnt_val=%0d res_data=%0d expected 0 0", cnt_val, res_data);
    end
    checks++;
    if (data_flat !== '0 || coef_flat !== '0) begin
      errors++;
      $display("FAIL reset_buffers: data or coef buffer not cleared");
    end
  endtask

  task automatic test_stream();
    int offset;
    int clr_count;
    int bad;
    node_out = 3'd6;
    drive_vector(16'd0, 1'b1);
    offset = 1;
    clr_count = 0;
    checks++;
    if (node_clr !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL stream_clr_first: node_clr=%b busy=%b expected 1 1", node_clr, busy);
    end
    bad = 0;
    for (int k = 0; k < N_IN; k++) begin
      if (node_clr) clr_count++;
      if (cnt_val !== 7'(k) || node_en !== 1'b1 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL stream_sweep: k=%0d cnt_val=%0d node_en=%b in_ready=%b expected %0d 1 0",
                 k, cnt_val, node_en, in_ready, k);
      end
      step();
      offset++;
    end
    checks++;
    if (bad != 0) errors++;
    checks++;
    if (node_en !== 1'b0 || cnt_val !== 7'd63) begin
      errors++;
      $display("FAIL stream_drain: node_en=%b cnt_val=%0d expected 0 63", node_en, cnt_val);
    end
    while (!res_valid && offset < 200) begin
      if (node_clr) clr_count++;
      step();
      offset++;
    end
    checks++;
    if (offset != 1 + 64 + LAT) begin
      errors++;
      $display("FAIL stream_latency: res_valid at T+%0d expected T+%0d", offset, 1 + 64 + LAT);
    end
    checks++;
    if (clr_count != 1) begin
      errors++;
      $display("FAIL stream_clr_count: got %0d pulses expected 1", clr_count);
    end
    checks++;
    if (res_data !== 3'd6 || cnt_val !== 7'd0) begin
      errors++;
      $display("FAIL stream_result: res_data=%0d cnt_val=%0d expected 6 0", res_data, cnt_val);
    end
    bad = 0;
    for (int i = 0; i < N_IN; i++)
      if (data_flat[i*WW +: WW] !== WW'(i) || coef_flat[i*WW +: WW] !== 16'd1) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stream_buffers: %0d words differ from data=i coef=1", bad);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stream_release: res_valid=%b busy=%b in_ready=%b expected 0 0 1",
               res_valid, busy, in_ready);
    end
  endtask

  task automatic test_sweep_ignore();
    node_out = 3'd5;
    drive_vector(16'd100, 1'b0);
    step();
    for (int k = 0; k < 10; k++) begin
      in_valid   = 1'b1;
      in_data    = 16'hAAAA;
      coef_we    = 1'b1;
      coef_addr  = 6'd3;
      coef_wdata = 16'hBEEF;
      step();
    end
    in_valid = 1'b0;
    coef_we  = 1'b0;
    checks++;
    if (coef_flat[3*WW +: WW] !== 16'd1) begin
      errors++;
      $display("FAIL ignore_coef: coef[3]=%h expected 0001", coef_flat[3*WW +: WW]);
    end
    checks++;
    if (data_flat[0 +: WW] !== 16'd100 || data_flat[3*WW +: WW] !== 16'd103 ||
        data_flat[63*WW +: WW] !== 16'd163) begin
      errors++;
      $display("FAIL ignore_data: words 0/3/63=%0d/%0d/%0d expected 100/103/163",
               data_flat[0 +: WW], data_flat[3*WW +: WW], data_flat[63*WW +: WW]);
    end
    wait_res("ignore_wait_res");
  endtask

  task automatic test_hold();
    int bad = 0;
    checks++;
    if (res_data !== 3'd5) begin
      errors++;
      $display("FAIL hold_capture: res_data=%0d expected 5", res_data);
    end
    node_out = 3'd1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (res_data !== 3'd5 || res_valid !== 1'b1 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL hold_stable: cycle %0d res_data=%0d res_valid=%b in_ready=%b expected 5 1 0",
                 k, res_data, res_valid, in_ready);
      end
    end
    checks++;
    if (bad != 0) errors++;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: res_valid=%b busy=%b expected 0 0", res_valid, busy);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    drive_vector(16'd200, 1'b0);
    while (cnt_val !== 7'd30 && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (cnt_val !== 7'd30) begin
      errors++;
      $display("FAIL rstmid_reach: cnt_val=%0d expected 30", cnt_val);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (cnt_val !== 7'd0 || node_en !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_state: cnt_val=%0d node_en=%b res_valid=%b busy=%b expected 0 0 0 0",
               cnt_val, node_en, res_valid, busy);
    end
    checks++;
    if (data_flat !== '0 || coef_flat !== '0) begin
      errors++;
      $display("FAIL rstmid_buffers: buffers not cleared");
    end
  endtask

  task automatic test_gaps();
    int bad = 0;
    for (int c = 0; c < 128; c++) begin
      in_valid = (c % 2 == 0);
      in_data  = 16'h1000 + WW'(c / 2);
      step();
      if (c == 124) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL gaps_early: busy=%b after 63 accepts expected 0", busy);
        end
      end
      if (c == 126) begin
        checks++;
        if (node_clr !== 1'b1 || busy !== 1'b1 || cnt_val !== 7'd0) begin
          errors++;
          $display("FAIL gaps_start: node_clr=%b busy=%b cnt_val=%0d expected 1 1 0",
                   node_clr, busy, cnt_val);
        end
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < N_IN; i++)
      if (data_flat[i*WW +: WW] !== 16'h1000 + WW'(i)) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL gaps_order: %0d words out of order (word0=%h word63=%h)",
               bad, data_flat[0 +: WW], data_flat[63*WW +: WW]);
    end
    checks++;
    if (cnt_val !== 7'd1 || node_clr !== 1'b0) begin
      errors++;
      $display("FAIL gaps_sweep: cnt_val=%0d node_clr=%b expected 1 0", cnt_val, node_clr);
    end
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    coef_we    = 1'b0;
    coef_addr  = '0;
    coef_wdata = '0;
    node_out   = '0;
    res_ready  = 1'b0;
    test_reset();
    test_stream();
    test_sweep_ignore();
    test_hold();
    test_reset_mid();
    test_gaps();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
